// File: rtl/min_unpooling.sv
//------------------------------------------------------------------------------
// min_unpooling
// Scatters a pooled minimum back into its window position, one element per cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module min_unpooling #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int size  = 4,
  parameter int width = $clog2(size)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 input_ready,
  input  logic [IL+FL-1:0]     val,
  input  logic [width-1:0]     idx,
  output logic [IL+FL-1:0]     om [size],
  output logic                 busy,
  output logic                 done
);

  localparam int c_dw = IL + FL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [width-1:0]  r_ptr;
  logic [c_dw-1:0]   r_val;
  logic [width-1:0]  r_idx;

  assign busy = (r_state == FILL);
  assign done = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_val   <= '0;
      r_idx   <= '0;
      for (int i = 0; i < size; i++) om[i] <= '0;
    end else if (en) begin
      case (r_state)
        IDLE, DONE: begin
          if (input_ready) begin
            r_val   <= val;
            r_idx   <= idx;
            r_ptr   <= '0;
            r_state <= FILL;
            for (int i = 0; i < size; i++) om[i] <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        FILL: begin
          // An out-of-range latched index never matches, leaving the window all zero.
          for (int i = 0; i < size; i++) begin
            if (r_ptr == width'(i))
              om[i] <= (r_ptr == r_idx) ? r_val : '0;
          end
          if (r_ptr == width'(size - 1)) begin
            r_ptr   <= '0;
            r_state <= DONE;
          end else begin
            r_ptr   <= r_ptr + width'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_min_unpooling.sv
//------------------------------------------------------------------------------
// tb_min_unpooling
// Directed and randomized checks of min_unpooling against a window-level model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_min_unpooling;

  localparam int IL   = 4;
  localparam int FL   = 16;
  localparam int SIZE = 4;
  localparam int W    = 2;
  localparam int DW   = IL + FL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          input_ready = 1'b0;
  logic [DW-1:0] val = '0;
  logic [W-1:0]  idx = '0;
  logic [DW-1:0] om [SIZE];
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  min_unpooling #(.IL(IL), .FL(FL), .size(SIZE), .width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .input_ready (input_ready),
    .val         (val),
    .idx         (idx),
    .om          (om),
    .busy        (busy),
    .done        (done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: enabled cycles elapsed since the load (0 = no window in progress),
  // plus the operands of the current window and the expected window contents.
  int            m_age = 0;
  logic [DW-1:0] m_val = '0;
  int            m_idx = 0;
  logic [DW-1:0] m_win [SIZE];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_load(input logic [DW-1:0] v, input int ix);
    m_val = v;
    m_idx = ix;
    m_age = 1;
    for (int j = 0; j < SIZE; j++) m_win[j] = '0;
  endtask

  task automatic model_edge(input logic r, input logic e, input logic ir,
                            input logic [DW-1:0] v, input logic [W-1:0] ix);
    if (!r) begin
      m_age = 0;
      m_val = '0;
      m_idx = 0;
      for (int j = 0; j < SIZE; j++) m_win[j] = '0;
    end else if (e) begin
      if (m_age == 0) begin
        if (ir) model_load(v, int'(ix));
      end else if (m_age <= SIZE) begin
        // Window element (age-1) becomes visible on this edge.
        if (m_age - 1 == m_idx) m_win[m_age-1] = m_val;
        m_age++;
      end else begin
        if (ir) model_load(v, int'(ix));
        else    m_age = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic ir,
                       input logic [DW-1:0] v, input logic [W-1:0] ix);
    @(negedge clk);
    rst_n = r; en = e; input_ready = ir; val = v; idx = ix;
    @(posedge clk);
    model_edge(r, e, ir, v, ix);
    #1;
    check("busy", 32'(busy), 32'(m_age >= 1 && m_age <= SIZE));
    check("done", 32'(done), 32'(m_age == SIZE + 1));
    for (int j = 0; j < SIZE; j++)
      check($sformatf("om[%0d]", j), 32'(om[j]), 32'(m_win[j]));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    for (int j = 0; j < SIZE; j++) m_win[j] = '0;

    // Reset, then the basic window with latency 5 to done
    cycle(1'b0, 1'b1, 1'b1, 20'h12345, 2'd1);
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 1'b1, 20'h08000, 2'd2);
    idle_cycles(6);

    // Back-to-back windows: second load in the done cycle
    cycle(1'b1, 1'b1, 1'b1, 20'hA5A5A, 2'd0);
    idle_cycles(4);
    cycle(1'b1, 1'b1, 1'b1, 20'h3C3C3, 2'd3);
    idle_cycles(6);

    // Enable dropped for 3 cycles after om[1] is written
    cycle(1'b1, 1'b1, 1'b1, 20'h00F0F, 2'd1);
    idle_cycles(2);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 20'hBEEF1, 2'd3);
    idle_cycles(4);

    // Load strobe during fill is ignored
    cycle(1'b1, 1'b1, 1'b1, 20'h11111, 2'd2);
    cycle(1'b1, 1'b1, 1'b1, 20'h99999, 2'd0);
    cycle(1'b1, 1'b1, 1'b1, 20'h77777, 2'd3);
    idle_cycles(4);

    // Reset mid-fill at pointer 2, then a normal window
    cycle(1'b1, 1'b1, 1'b1, 20'h55555, 2'd3);
    idle_cycles(2);
    cycle(1'b0, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 1'b1, 20'hFFFFF, 2'd1);
    idle_cycles(6);

    // Zero value yields an all-zero window
    cycle(1'b1, 1'b1, 1'b1, 20'h00000, 2'd2);
    idle_cycles(5);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic          r, e, ir;
      logic [DW-1:0] v;
      r  = ($urandom_range(0, 99) >= 3);
      e  = ($urandom_range(0, 99) >= 20);
      ir = ($urandom_range(0, 99) < 35);
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = '1;
        default: v = DW'($urandom);
      endcase
      cycle(r, e, ir, v, W'($urandom_range(0, SIZE - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/min_unpooling.md
MIN_UNPOOLING -- requirements
Module: min_unpooling

Interface
REQ-001 Parameter IL, default 4, integer bits of the fixed-point value.
REQ-002 Parameter FL, default 16, fractional bits of the fixed-point value.
REQ-003 Parameter size, default 4, number of elements in the window.
REQ-004 Parameter width, default $clog2(size), index and pointer width.
REQ-005 The block SHALL provide one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  synchronous reset, active-low.
REQ-008 en  input  1  clock enable; low SHALL hold all state and outputs.
REQ-009 input_ready  input  1  load strobe for val and idx.
REQ-010 val  input  IL+FL  pooled minimum value to scatter.
REQ-011 idx  input  width  window position of the minimum (argmin).
REQ-012 om  output  [IL+FL-1:0] x size (unpacked)  reconstructed window.
REQ-013 busy  output  1  high while the window is being filled.
REQ-014 done  output  1  one-cycle completion flag.

Function
REQ-015 The FSM SHALL have the states IDLE, FILL and DONE; busy = (state==FILL) and done = (state==DONE), both decoded combinationally from the state.
REQ-016 IDLE with en=1 and input_ready=1 SHALL latch val and idx, clear pointer to 0, clear every om element to 0, and move to FILL.
REQ-017 FILL with en=1 SHALL write om[pointer] <= (pointer==idx_latched) ? val_latched : 0 and then increment pointer.
REQ-018 FILL SHALL move to DONE on the edge that writes om[size-1]; pointer SHALL then wrap to 0.
REQ-019 DONE with en=1 SHALL last exactly one cycle.
    - If input_ready=1 in that cycle, the block SHALL perform the REQ-016 load and go to FILL (back-to-back window).
    - Otherwise the block SHALL go to IDLE.
    - om SHALL keep the completed window until the next load clears it.
REQ-020 Latency: load edge E0, fill edges E1..E(size); done SHALL be high in the cycle after E(size), that is, size+1 cycles after input_ready is sampled.
REQ-021 input_ready during FILL SHALL be ignored; latched val and idx SHALL not change.
REQ-022 en=0 in any state SHALL freeze state, pointer, latched operands and om; the sequence SHALL resume unchanged when en returns to 1, with done/busy held at their decoded values.
REQ-023 If idx_latched >= size (size not a power of two), every om element SHALL be 0.
REQ-024 val SHALL be copied bit-exact with no sign extension, rounding or saturation.
REQ-025 Exactly one om element SHALL be nonzero-capable per window; a val of 0 SHALL yield an all-zero window.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state IDLE, pointer 0, latched val/idx 0 and all om elements 0, so busy=0 and done=0.
REQ-027 Reset SHALL take priority over en and input_ready.
REQ-028 Reset in the middle of FILL SHALL abandon the window with no done pulse.
REQ-029 Reset SHALL not be required for the first load; a load after reset deassertion SHALL be accepted on the first edge.

Verification
REQ-030 size=4, val=0x0_8000, idx=2, en=1 steady -> om={0,0,0x0_8000,0}; done high exactly in cycle 5 after load; busy high in cycles 1-4.
REQ-031 idx=0, then idx=3 loaded in the DONE cycle -> first window has om[0]=val; second window fills with no IDLE cycle; two done pulses 5 cycles apart.
REQ-032 en dropped for 3 cycles after om[1] is written -> om, pointer and busy frozen; done arrives 3 cycles late with the correct window.
REQ-033 input_ready pulsed with new val/idx during FILL -> ignored; window reflects the original operands.
REQ-034 rst_n low during FILL at pointer=2 -> next cycle om all 0, busy=0, no done; a subsequent load completes normally.
REQ-035 val=0xF_FFFF at idx=1 (full-width pattern) -> om[1]=0xF_FFFF exactly; other elements 0.
